button_pulse_gen: RTL and testbench

- Produces the one-cycle `pulse` strobe that the start/stop control FSM consumes. Each physical press of a bouncy push-button yields exactly one pulse.
- Contains a 2-FF synchroniser, a debounce counter and a press/release confirmation FSM.
- Sits between the board button pin and the run-control logic. It also exports a debounced level and a release strobe for the display/lap logic.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 32 +++
 rtl/button_pulse_gen.sv | 121 ++++++++++++
 tb/tb_button_pulse_gen.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
//------------------------------------------------------------------------------
// Module      : timer_pkg
// Description : Shared FSM encodings and debounce default for button inputs.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package timer_pkg;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_CONF_PRESS = 2'd1;
  localparam state_t ST_HELD       = 2'd2;
  localparam state_t ST_CONF_REL   = 2'd3;

endpackage : timer_pkg

`default_nettype wire

// File: rtl/sync_2ff.sv
//------------------------------------------------------------------------------
// Module      : sync_2ff
// Description : 1-bit two-flop synchroniser with asynchronous active-low clear.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= d;
      r_s2 <= r_s1;
    end
  end

  assign q = r_s2;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/button_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : button_pulse_gen
// Description : Debounced push-button to one-cycle press/release strobes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module button_pulse_gen
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic pulse,
  output logic release_pulse,
  output logic btn_level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_btn_s;
  logic             w_cnt_done;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             r_release;
  logic             r_level;
  logic             w_pulse_nxt;
  logic             w_release_nxt;
  logic             w_level_nxt;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_in),
    .q     (w_btn_s)
  );

  assign w_cnt_done = (r_cnt == c_cnt_max);

  // State register; strobes and level are registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      r_level   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_release <= w_release_nxt;
      r_level   <= w_level_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = ST_CONF_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      ST_CONF_PRESS: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (!w_btn_s) begin
          w_state_nxt = ST_CONF_REL;
          w_cnt_nxt   = '0;
        end
      end
      ST_CONF_REL: begin
        if (w_btn_s) begin
          w_state_nxt = ST_HELD;
          w_cnt_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level follows the upcoming state so it moves in the same cycle as a strobe.
  always_comb begin
    w_pulse_nxt   = (r_state == ST_CONF_PRESS) && w_btn_s && w_cnt_done;
    w_release_nxt = (r_state == ST_CONF_REL) && !w_btn_s && w_cnt_done;
    w_level_nxt   = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_CONF_REL);
  end

  assign pulse         = r_pulse;
  assign release_pulse = r_release;
  assign btn_level     = r_level;

endmodule : button_pulse_gen

`default_nettype wire

// File: tb/tb_button_pulse_gen.sv
//------------------------------------------------------------------------------
// Module      : tb_button_pulse_gen
// Description : Directed vector bench for button_pulse_gen (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_button_pulse_gen;

  typedef struct {
    logic       btn;
    logic [2:0] exp;   // {pulse, release_pulse, btn_level}
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_in = 1'b0;
  logic pulse;
  logic release_pulse;
  logic btn_level;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  button_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .btn_in        (btn_in),
    .pulse         (pulse),
    .release_pulse (release_pulse),
    .btn_level     (btn_level)
  );

  always #5 clk = ~clk;

  task automatic seg(input int n, input logic b, input logic [2:0] e);
    vec_t v;
    v.btn = b;
    v.exp = e;
    for (int i = 0; i < n; i++) tbl.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input logic [2:0] e);
    logic [2:0] got;
    got = {pulse, release_pulse, btn_level};
    n_cmp++;
    if (got !== e) begin
      n_bad++;
      $display("FAIL %s[%0d]: got {pulse,rel,level}=%b want %b", name, idx, got, e);
    end
  endtask

  task automatic step(input logic b);
    btn_in = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with the button toggling: everything stays low.
    rst_n = 1'b0;
    #1;
    check("reset_async", 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      step(i[0] ? 1'b0 : 1'b1);
      check("reset", i, 3'b000);
    end
    btn_in = 1'b0;
    rst_n  = 1'b1;

    // Clean press, held, then release with bounce 0,1,0.
    seg(6,  1'b1, 3'b000);
    seg(1,  1'b1, 3'b101);
    seg(13, 1'b1, 3'b001);
    seg(1,  1'b0, 3'b001);
    seg(1,  1'b1, 3'b001);
    seg(6,  1'b0, 3'b001);
    seg(1,  1'b0, 3'b010);
    seg(6,  1'b0, 3'b000);
    // Bounce on press 1,0,1,1,0,1 then steady.
    seg(1,  1'b1, 3'b000);
    seg(1,  1'b0, 3'b000);
    seg(2,  1'b1, 3'b000);
    seg(1,  1'b0, 3'b000);
    seg(6,  1'b1, 3'b000);
    seg(1,  1'b1, 3'b101);
    seg(6,  1'b1, 3'b001);
    // Clean release.
    seg(6,  1'b0, 3'b001);
    seg(1,  1'b0, 3'b010);
    seg(5,  1'b0, 3'b000);
    // 3-cycle and 4-cycle glitches: no output.
    seg(3,  1'b1, 3'b000);
    seg(12, 1'b0, 3'b000);
    seg(4,  1'b1, 3'b000);
    seg(12, 1'b0, 3'b000);
    // 5-cycle press: shortest that confirms, followed by immediate release.
    seg(5,  1'b1, 3'b000);
    seg(1,  1'b0, 3'b000);
    seg(1,  1'b0, 3'b101);
    seg(4,  1'b0, 3'b001);
    seg(1,  1'b0, 3'b010);
    seg(4,  1'b0, 3'b000);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].btn);
      check("vec", i, tbl[i].exp);
    end

    // Long hold: one pulse, then 50 cycles with none.
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      check("hold_press", i, (i == 6) ? 3'b101 : 3'b000);
    end
    for (int i = 0; i < 50; i++) begin
      step(1'b1);
      check("hold_50", i, 3'b001);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      check("hold_release", i, (i == 6) ? 3'b010 : ((i < 6) ? 3'b001 : 3'b000));
    end

    // Reset two cycles into press confirmation, button kept high throughout.
    for (int i = 0; i < 4; i++) begin
      step(1'b1);
      check("pre_reset", i, 3'b000);
    end
    rst_n = 1'b0;
    #1;
    check("mid_reset_async", 0, 3'b000);
    for (int i = 0; i < 2; i++) begin
      step(1'b1);
      check("mid_reset", i, 3'b000);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      check("post_reset", i, (i == 6) ? 3'b101 : ((i > 6) ? 3'b001 : 3'b000));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_button_pulse_gen

`default_nettype wire
